// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash-like responder: opcodes, FSM states,
// status register layout and small byte-select helpers.
package spi_flash_pkg;

    localparam logic [7:0] OP_READ    = 8'h03;
    localparam logic [7:0] OP_PROGRAM = 8'h02;
    localparam logic [7:0] OP_RDSR    = 8'h05;
    localparam logic [7:0] OP_RDID    = 8'h9F;
    localparam logic [7:0] OP_WREN    = 8'h06;
    localparam logic [7:0] OP_WRDI    = 8'h04;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_WEL_BIT  = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_RD     = 3'd3,
        ST_WR     = 3'd4,
        ST_RDSR   = 3'd5,
        ST_RDID   = 3'd6,
        ST_IGNORE = 3'd7
    } state_t;

    function automatic logic [7:0] status_byte(input logic wel);
        logic [7:0] s;
        s                  = 8'h00;
        s[STATUS_WEL_BIT]  = wel;
        s[STATUS_BUSY_BIT] = 1'b0;
        return s;
    endfunction

    function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = id[23:16];
            2'd1:    b = id[15:8];
            default: b = id[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_flash_sync.sv
// Two-flop synchronizers for the SPI pads plus edge strobes derived from the
// synchronized SCK and NSS.
module spi_flash_sync
    import spi_flash_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic sck_i,
    input  logic nss_i,
    input  logic mosi_i,
    output logic nss_o,
    output logic mosi_o,
    output logic sck_rise_o,
    output logic sck_fall_o,
    output logic nss_fall_o,
    output logic nss_rise_o
);

    logic r_sck_meta, r_sck_sync, r_sck_prev;
    logic r_nss_meta, r_nss_sync, r_nss_prev;
    logic r_mosi_meta, r_mosi_sync;

    // Synchronizer chains; NSS resets to the deselected level
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sck_meta  <= 1'b0;
            r_sck_sync  <= 1'b0;
            r_sck_prev  <= 1'b0;
            r_nss_meta  <= 1'b1;
            r_nss_sync  <= 1'b1;
            r_nss_prev  <= 1'b1;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_sck_meta  <= sck_i;
            r_sck_sync  <= r_sck_meta;
            r_sck_prev  <= r_sck_sync;
            r_nss_meta  <= nss_i;
            r_nss_sync  <= r_nss_meta;
            r_nss_prev  <= r_nss_sync;
            r_mosi_meta <= mosi_i;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    assign nss_o      = r_nss_sync;
    assign mosi_o     = r_mosi_sync;
    assign sck_rise_o = r_sck_sync & ~r_sck_prev;
    assign sck_fall_o = ~r_sck_sync & r_sck_prev;
    assign nss_fall_o = ~r_nss_sync & r_nss_prev;
    assign nss_rise_o = r_nss_sync & ~r_nss_prev;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash-like target: READ/PROGRAM/RDSR/RDID/WREN/WRDI over an
// internal byte memory, oversampled in clk_i.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          DEPTH    = 256,
    parameter logic [23:0] JEDEC_ID = 24'hEF4018,
    localparam int         AW       = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          spi_sck_i,
    input  logic          spi_nss_i,
    input  logic          spi_mosi_i,
    output logic          spi_miso_o,
    output logic          spi_miso_en_o,
    output logic          busy_o,
    output logic          wr_valid_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [7:0]    wr_data_o,
    output logic          cmd_err_o
);

    localparam logic [AW-1:0] ADDR_ONE = AW'(1);

    logic w_nss_s, w_mosi_s, w_sck_rise, w_sck_fall, w_nss_fall, w_nss_rise;

    spi_flash_sync u_sync (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .sck_i      (spi_sck_i),
        .nss_i      (spi_nss_i),
        .mosi_i     (spi_mosi_i),
        .nss_o      (w_nss_s),
        .mosi_o     (w_mosi_s),
        .sck_rise_o (w_sck_rise),
        .sck_fall_o (w_sck_fall),
        .nss_fall_o (w_nss_fall),
        .nss_rise_o (w_nss_rise)
    );

    state_t        r_state, w_next_state;
    logic [4:0]    r_bit_cnt;
    logic [2:0]    r_tx_cnt;
    logic [6:0]    r_shift;
    logic [7:0]    r_tx;
    logic [AW-1:0] r_addr;
    logic [1:0]    r_id_idx;
    logic          r_wel, r_is_prog;
    logic          r_miso, r_miso_en;
    logic          r_wr_valid, r_cmd_err;
    logic [AW-1:0] r_wr_addr;
    logic [7:0]    r_wr_data;
    logic [7:0]    r_mem [DEPTH];

    logic [7:0]    w_byte_in;
    logic [AW-1:0] w_addr_shift, w_addr_inc;

    assign w_byte_in    = {r_shift, w_mosi_s};
    assign w_addr_shift = {r_addr[AW-2:0], w_mosi_s};
    assign w_addr_inc   = r_addr + ADDR_ONE;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a deselected target always returns to IDLE first
    always_comb begin
        w_next_state = r_state;
        if (w_nss_s) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_nss_fall) w_next_state = ST_CMD;
                    else            w_next_state = ST_IDLE;
                end
                ST_CMD: begin
                    if (w_sck_rise && r_bit_cnt == 5'd7) begin
                        case (w_byte_in)
                            OP_READ, OP_PROGRAM: w_next_state = ST_ADDR;
                            OP_RDSR:             w_next_state = ST_RDSR;
                            OP_RDID:             w_next_state = ST_RDID;
                            default:             w_next_state = ST_IGNORE;
                        endcase
                    end else begin
                        w_next_state = ST_CMD;
                    end
                end
                ST_ADDR: begin
                    if (w_sck_rise && r_bit_cnt == 5'd23) w_next_state = r_is_prog ? ST_WR : ST_RD;
                    else                                   w_next_state = ST_ADDR;
                end
                default: w_next_state = r_state;
            endcase
        end
    end

    // Transaction datapath: shifters, counters, WEL, memory and output pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bit_cnt  <= 5'd0;
            r_tx_cnt   <= 3'd0;
            r_shift    <= 7'd0;
            r_tx       <= 8'h00;
            r_addr     <= '0;
            r_id_idx   <= 2'd0;
            r_wel      <= 1'b0;
            r_is_prog  <= 1'b0;
            r_miso     <= 1'b0;
            r_miso_en  <= 1'b0;
            r_wr_valid <= 1'b0;
            r_cmd_err  <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= 8'h00;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
        end else begin
            r_wr_valid <= 1'b0;
            r_cmd_err  <= 1'b0;
            if (w_nss_s) begin
                // End of a PROGRAM (finished or aborted) always drops WEL
                if (w_nss_rise && r_is_prog) r_wel <= 1'b0;
                r_is_prog <= 1'b0;
                r_miso    <= 1'b0;
                r_miso_en <= 1'b0;
                r_bit_cnt <= 5'd0;
                r_tx_cnt  <= 3'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_bit_cnt <= 5'd0;
                        r_tx_cnt  <= 3'd0;
                    end
                    ST_CMD: begin
                        if (w_sck_rise) begin
                            r_shift <= w_byte_in[6:0];
                            if (r_bit_cnt == 5'd7) begin
                                r_bit_cnt <= 5'd0;
                                r_tx_cnt  <= 3'd0;
                                case (w_byte_in)
                                    OP_READ:    r_is_prog <= 1'b0;
                                    OP_PROGRAM: r_is_prog <= 1'b1;
                                    OP_RDSR:    r_tx      <= status_byte(r_wel);
                                    OP_RDID: begin
                                        r_tx     <= id_byte(JEDEC_ID, 2'd0);
                                        r_id_idx <= 2'd1;
                                    end
                                    OP_WREN:    r_wel     <= 1'b1;
                                    OP_WRDI:    r_wel     <= 1'b0;
                                    default:    r_cmd_err <= 1'b1;
                                endcase
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (w_sck_rise) begin
                            r_addr <= w_addr_shift;
                            if (r_bit_cnt == 5'd23) begin
                                r_bit_cnt <= 5'd0;
                                r_tx_cnt  <= 3'd0;
                                if (!r_is_prog) r_tx <= r_mem[w_addr_shift];
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_RD, ST_RDSR, ST_RDID: begin
                        if (w_sck_fall) begin
                            r_miso_en <= 1'b1;
                            r_miso    <= r_tx[7];
                            r_tx      <= {r_tx[6:0], 1'b0};
                            if (r_tx_cnt == 3'd7) begin
                                r_tx_cnt <= 3'd0;
                                case (r_state)
                                    ST_RD: begin
                                        r_addr <= w_addr_inc;
                                        r_tx   <= r_mem[w_addr_inc];
                                    end
                                    ST_RDSR: r_tx <= status_byte(r_wel);
                                    default: begin
                                        r_tx     <= id_byte(JEDEC_ID, r_id_idx);
                                        r_id_idx <= (r_id_idx == 2'd2) ? 2'd0 : r_id_idx + 2'd1;
                                    end
                                endcase
                            end else begin
                                r_tx_cnt <= r_tx_cnt + 3'd1;
                            end
                        end
                    end
                    ST_WR: begin
                        if (w_sck_rise) begin
                            r_shift <= w_byte_in[6:0];
                            if (r_bit_cnt == 5'd7) begin
                                r_bit_cnt <= 5'd0;
                                if (r_wel) begin
                                    r_mem[r_addr] <= w_byte_in;
                                    r_wr_valid    <= 1'b1;
                                    r_wr_addr     <= r_addr;
                                    r_wr_data     <= w_byte_in;
                                    r_addr        <= w_addr_inc;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end
                    default: begin
                        r_miso_en <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Gate with synced NSS so MISO releases in the same cycle deselect is seen
    assign spi_miso_o    = r_miso & ~w_nss_s;
    assign spi_miso_en_o = r_miso_en & ~w_nss_s;
    assign busy_o        = ~w_nss_s;
    assign wr_valid_o    = r_wr_valid;
    assign wr_addr_o     = r_wr_addr;
    assign wr_data_o     = r_wr_data;
    assign cmd_err_o     = r_cmd_err;

endmodule
